entropy_stream_scheduler: RTL and testbench
===========================================

ENTROPY_STREAM_SCHEDULER -- requirements
Module: entropy_stream_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, sample-FIFO depth in bytes; power of two, 2..16.
REQ-002 Parameter STATUS_ID, default 4'hA, constant upper nibble of the status byte.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 word_ready  input  1  one-cycle pulse: new entropy word valid on sample.
REQ-006 sample  input  8  entropy byte (LFSR low byte), valid when word_ready high.
REQ-007 rx_valid  input  1  one-cycle pulse from UART: rx_byte holds a received byte.
REQ-008 rx_byte  input  8  received command or argument byte.
REQ-009 tx_busy  input  1  UART is_transmitting.
REQ-010 transmit  output  1  one-cycle pulse: UART loads tx_byte.
REQ-011 tx_byte  output  8  byte to send; stable while transmit high.
REQ-012 datapath_rst  output  1  one-cycle pulse requesting entropy-datapath reset.
REQ-013 overflow  output  1  sticky: a sample was dropped because the FIFO was full.

Function
REQ-014 Mode FSM states: PAUSED, STREAM, BURST, ARG; reset state PAUSED.
REQ-015 Commands, decoded only on rx_valid and only outside ARG:
  - 0x73 's': go to STREAM.
  - 0x70 'p': go to PAUSED.
  - 0x6E 'n': go to ARG.
  - 0x72 'r': pulse datapath_rst next cycle, flush FIFO, clear overflow; mode unchanged.
  - 0x3F '?': set status_pending.
  - Any other byte: ignored.
REQ-016 In ARG, the next rx_valid byte loads the 8-bit burst counter. Value 0 goes to PAUSED; otherwise go to BURST.
REQ-017 FIFO write: word_ready in STREAM or BURST pushes sample. In PAUSED or ARG, samples are discarded and overflow is unchanged.
REQ-018 Full FIFO plus word_ready: sample dropped, overflow set to 1. Simultaneous push and pop on a full FIFO is accepted and not counted as a drop.
REQ-019 A pointer wrap at DEPTH is transparent; occupancy counter width is clog2(DEPTH)+1.
REQ-020 Transmit eligibility: tx_busy low and the holdoff counter zero.
REQ-021 Priority when eligible:
  - status_pending: send status byte.
  - Otherwise, FIFO non-empty in STREAM or BURST: pop and send.
  - Otherwise, no transmit.
REQ-022 Status byte layout:
  - [7:4] = STATUS_ID.
  - [3] = overflow.
  - [2] = FIFO empty.
  - [1:0] = mode (PAUSED=0, STREAM=1, BURST=2, ARG=3).
  - Sampled on the cycle transmit is asserted; status_pending clears on that cycle.
REQ-023 On each transmit pulse, the holdoff counter loads 2 and decrements to 0. No further transmit is issued before it reaches 0, regardless of tx_busy.
REQ-024 BURST: each entropy byte sent decrements the burst counter. Reaching 0 moves to PAUSED in the same cycle; status bytes do not decrement it.
REQ-025 Mode change to PAUSED does not flush the FIFO; remaining bytes are held until STREAM or BURST resumes.
REQ-026 A new 'n' during BURST aborts the burst (to ARG); the counter is reloaded by the argument.
REQ-027 '?' while status_pending is already set: no second status byte is queued.
REQ-028 word_ready and rx_valid 'r' in the same cycle: flush wins and the sample is discarded.

Reset
REQ-029 While rst_n is low at a clock edge, the block enters this state:
  - Mode PAUSED.
  - FIFO empty; overflow=0; status_pending=0.
  - Burst counter 0; holdoff 0.
  - transmit=0; tx_byte=8'h00; datapath_rst=0.
REQ-030 Reset asserted mid-transmit drops any pending or in-flight byte bookkeeping; no transmit is issued during reset or in the first cycle after release.
REQ-031 The first transmit can occur no earlier than the second cycle after rst_n rises.

Verification
REQ-032 Reset, then rx 0x73, then word_ready with samples 0x11, 0x22, 0x33, tx_busy held low: transmit pulses carry 0x11, 0x22, 0x33 in order, at least 3 cycles apart.
REQ-033 rx 0x6E, 0x02 in STREAM, then 5 samples: exactly 2 entropy bytes are sent, then mode PAUSED, and a following '?' returns 0xA0 | empty-bit as appropriate.
REQ-034 STREAM, tx_busy held high, 6 samples with DEPTH=4: 4 buffered, overflow=1; '?' after tx_busy falls returns 0xA9 (overflow, non-empty, STREAM) before any buffered entropy.
REQ-035 FIFO holding 3 bytes with overflow=1, rx 0x72: datapath_rst pulses once, FIFO empty, overflow=0, and mode is retained.
REQ-036 rst_n low for 1 cycle during BURST with 2 bytes queued: all outputs return to REQ-029 values, and no transmit occurs until a new 's' or 'n' command plus a sample arrive.

Source files
------------

// File: rtl/entropy_stream_scheduler_if.sv
// entropy_stream_scheduler_if: entropy sample, UART rx/tx and status signals for the scheduler
interface entropy_stream_scheduler_if;
    logic       word_ready;
    logic [7:0] sample;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_busy;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       datapath_rst;
    logic       overflow;
    modport master(output word_ready, sample, rx_valid, rx_byte, tx_busy,
                   input transmit, tx_byte, datapath_rst, overflow);
    modport slave(input word_ready, sample, rx_valid, rx_byte, tx_busy,
                  output transmit, tx_byte, datapath_rst, overflow);
endinterface

// File: rtl/entropy_stream_scheduler.sv
// entropy_stream_scheduler: buffers entropy bytes and schedules UART transmits under command control
module entropy_stream_scheduler #(
    parameter int         DEPTH     = 4,
    parameter logic [3:0] STATUS_ID = 4'hA
) (
    input logic                         clk,
    input logic                         rst_n,
    entropy_stream_scheduler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {PAUSED = 2'd0, STREAM = 2'd1, BURST = 2'd2, ARG = 2'd3} mode_t;
    mode_t         mode_q, mode_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    burst_q, burst_d, tx_byte_q, tx_byte_d;
    logic [1:0]    hold_q, hold_d;
    logic          ovf_q, ovf_d, stat_q, stat_d, trans_q, trans_d, dprst_q, dprst_d;
    logic          cmd, flush, streaming, eligible, send_status, pop, full, push, drop;

    always_comb begin
        cmd         = bus.rx_valid && mode_q != ARG;
        flush       = cmd && bus.rx_byte == 8'h72;
        streaming   = mode_q == STREAM || mode_q == BURST;
        eligible    = !bus.tx_busy && hold_q == 2'd0;
        send_status = eligible && stat_q;
        pop         = eligible && !stat_q && streaming && cnt_q != '0;
        full        = cnt_q == (AW+1)'(DEPTH);
        push        = bus.word_ready && streaming && !flush && (!full || pop);
        drop        = bus.word_ready && streaming && !flush && full && !pop;
        rd_d        = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
        wr_d        = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
        cnt_d       = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d       = flush ? 1'b0 : ovf_q | drop;
        stat_d      = (stat_q && !send_status) || (cmd && bus.rx_byte == 8'h3F);
        trans_d     = send_status || pop;
        tx_byte_d   = send_status ? {STATUS_ID, ovf_q, cnt_q == '0, 2'(mode_q)} :
                      pop ? mem_q[rd_q] : tx_byte_q;
        hold_d      = trans_d ? 2'd2 : hold_q != 2'd0 ? hold_q - 2'd1 : 2'd0;
        dprst_d     = flush;
        mode_d      = mode_q;
        burst_d     = burst_q;
        if (pop && mode_q == BURST) begin
            burst_d = burst_q - 8'd1;
            mode_d  = burst_q == 8'd1 ? PAUSED : mode_q;
        end
        // Commands override a same-cycle burst expiry
        if (bus.rx_valid && mode_q == ARG) begin
            burst_d = bus.rx_byte;
            mode_d  = bus.rx_byte == 8'd0 ? PAUSED : BURST;
        end else if (cmd) begin
            mode_d = bus.rx_byte == 8'h73 ? STREAM :
                     bus.rx_byte == 8'h70 ? PAUSED :
                     bus.rx_byte == 8'h6E ? ARG : mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= PAUSED;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            burst_q   <= 8'd0;
            tx_byte_q <= 8'd0;
            hold_q    <= 2'd0;
            ovf_q     <= 1'b0;
            stat_q    <= 1'b0;
            trans_q   <= 1'b0;
            dprst_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            tx_byte_q <= tx_byte_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
            stat_q    <= stat_d;
            trans_q   <= trans_d;
            dprst_q   <= dprst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.sample;
    end

    assign bus.transmit     = trans_q;
    assign bus.tx_byte      = tx_byte_q;
    assign bus.datapath_rst = dprst_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_entropy_stream_scheduler.sv
// tb_entropy_stream_scheduler: directed and random stimulus against a queue-based reference model
module tb_entropy_stream_scheduler;
    localparam int         DEPTH = 4;
    localparam logic [3:0] SID   = 4'hA;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    entropy_stream_scheduler_if bus();
    entropy_stream_scheduler #(.DEPTH(DEPTH), .STATUS_ID(SID)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo[$];
    logic [7:0] seen[$];
    int m_mode = 0, m_burst = 0, m_hold = 0;
    bit m_ovf = 0, m_pend = 0, m_tx = 0, m_dprst = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Modes: 0 paused, 1 stream, 2 burst, 3 waiting for burst argument
    task automatic model_step();
        int  mode0;
        bit  elig, do_stat, do_pop, streaming, cmd, flush;
        if (!rst_n) begin
            m_mode = 0; m_burst = 0; m_hold = 0;
            m_ovf = 0; m_pend = 0; m_tx = 0; m_dprst = 0;
            fifo.delete();
            exp_q.delete();
            return;
        end
        mode0     = m_mode;
        streaming = mode0 == 1 || mode0 == 2;
        elig      = !bus.tx_busy && m_hold == 0;
        do_stat   = elig && m_pend;
        do_pop    = elig && !m_pend && streaming && fifo.size() > 0;
        cmd       = bus.rx_valid && mode0 != 3;
        flush     = cmd && bus.rx_byte == 8'h72;
        if (do_stat)
            exp_q.push_back({SID, m_ovf, fifo.size() == 0, 2'(mode0)});
        if (do_pop) begin
            exp_q.push_back(fifo.pop_front());
            if (mode0 == 2) begin
                m_burst--;
                if (m_burst == 0) m_mode = 0;
            end
        end
        if (bus.word_ready && streaming && !flush) begin
            if (fifo.size() < DEPTH) fifo.push_back(bus.sample);
            else m_ovf = 1;
        end
        m_tx   = do_stat || do_pop;
        m_hold = m_tx ? 2 : (m_hold > 0 ? m_hold - 1 : 0);
        m_pend = (m_pend && !do_stat) || (cmd && bus.rx_byte == 8'h3F);
        m_dprst = flush;
        if (flush) begin
            fifo.delete();
            m_ovf = 0;
        end
        if (bus.rx_valid && mode0 == 3) begin
            m_burst = int'(bus.rx_byte);
            m_mode  = bus.rx_byte == 8'd0 ? 0 : 2;
        end else if (cmd) begin
            if (bus.rx_byte == 8'h73) m_mode = 1;
            else if (bus.rx_byte == 8'h70) m_mode = 0;
            else if (bus.rx_byte == 8'h6E) m_mode = 3;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("transmit", int'(bus.transmit), int'(m_tx));
        check("datapath_rst", int'(bus.datapath_rst), int'(m_dprst));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        if (bus.transmit && m_tx) begin
            seen.push_back(bus.tx_byte);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_byte: got %0h, expected nothing queued at %0t", bus.tx_byte, $time);
            end else begin
                check("tx_byte", int'(bus.tx_byte), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input bit wr = 0, input logic [7:0] s = 8'h00, input bit rv = 0,
                        input logic [7:0] rb = 8'h00, input bit busy = 0);
        bus.word_ready = wr;
        bus.sample     = s;
        bus.rx_valid   = rv;
        bus.rx_byte    = rb;
        bus.tx_busy    = busy;
        @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] b, input bit busy = 0);
        step(0, 8'h00, 1, b, busy);
    endtask

    task automatic smp(input logic [7:0] s, input bit busy = 0);
        step(1, s, 0, 8'h00, busy);
    endtask

    task automatic idle(input int n, input bit busy = 0);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, busy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_transmit"}, int'(bus.transmit), 0);
        check({tag, "_tx_byte"}, int'(bus.tx_byte), 0);
        check({tag, "_datapath_rst"}, int'(bus.datapath_rst), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    logic [7:0] cmds [6] = '{8'h73, 8'h70, 8'h6E, 8'h72, 8'h3F, 8'h02};

    initial begin
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Stream three samples in order
        cmd(8'h73);
        idle(1);
        seen.delete();
        smp(8'h11); smp(8'h22); smp(8'h33);
        idle(12);
        check("stream_count", seen.size(), 3);
        if (seen.size() == 3) begin
            check("stream_b0", int'(seen[0]), 8'h11);
            check("stream_b1", int'(seen[1]), 8'h22);
            check("stream_b2", int'(seen[2]), 8'h33);
        end

        // Burst of two from STREAM, then status shows PAUSED with leftovers
        cmd(8'h6E); cmd(8'h02);
        seen.delete();
        for (int i = 0; i < 5; i++) smp(8'(8'h40 + i));
        idle(10);
        cmd(8'h3F);
        idle(6);
        check("burst_count", seen.size(), 3);
        if (seen.size() == 3) check("burst_status", int'(seen[2]), 8'hA0);

        // Overflow while tx is busy, status goes out ahead of entropy
        cmd(8'h72);
        cmd(8'h73);
        for (int i = 0; i < 6; i++) smp(8'(8'h60 + i), 1);
        check("ovf_set", int'(bus.overflow), 1);
        cmd(8'h3F, 1);
        idle(1, 1);
        seen.delete();
        idle(20);
        check("ovf_count", seen.size(), 5);
        if (seen.size() > 0) check("ovf_status", int'(seen[0]), 8'hA9);

        // Flush with three queued bytes and overflow set
        for (int i = 0; i < 3; i++) smp(8'(8'h70 + i), 1);
        check("flush_pre_ovf", int'(bus.overflow), 1);
        cmd(8'h72, 1);
        check("flush_dprst", int'(bus.datapath_rst), 1);
        check("flush_ovf", int'(bus.overflow), 0);
        idle(1, 1);
        check("flush_dprst_once", int'(bus.datapath_rst), 0);
        cmd(8'h3F);
        seen.delete();
        idle(6);
        check("flush_status_count", seen.size(), 1);
        if (seen.size() == 1) check("flush_status", int'(seen[0]), 8'hA5);

        // Reset mid-burst with bytes queued
        cmd(8'h6E, 1); cmd(8'h05, 1);
        smp(8'h81, 1); smp(8'h82, 1);
        rst_n = 1'b0;
        idle(1, 1);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        seen.delete();
        idle(5);
        smp(8'h90);
        idle(5);
        check("midrst_silent", seen.size(), 0);
        cmd(8'h73);
        smp(8'h91);
        idle(4);
        check("midrst_resume", seen.size(), 1);
        if (seen.size() == 1) check("midrst_byte", int'(seen[0]), 8'h91);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit wr, rv, busy;
            logic [7:0] s, rb;
            int k;
            wr   = $urandom_range(0, 9) < 4;
            s    = 8'($urandom);
            rv   = $urandom_range(0, 99) < 6;
            k    = $urandom_range(0, 6);
            rb   = k < 6 ? cmds[k] : 8'($urandom);
            busy = $urandom_range(0, 9) < 3;
            rst_n = !($urandom_range(0, 999) < 2);
            step(wr, s, rv, rb, busy);
        end
        rst_n = 1'b1;
        cmd(8'h73);
        idle(40);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
